// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit after last_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_ptr,
    output logic               any,
    output logic [SEL_W-1:0]   pick
);

    logic [SEL_W-1:0] idx;

    // Walk farthest-to-nearest so the nearest set bit after last_ptr wins.
    always_comb begin
        any  = |req;
        pick = last_ptr;
        idx  = last_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_ptr + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, registered output with valid/ready.
// Optional requester lock when MUX_ARB_LOCK_EN is defined.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   data0,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [WIDTH-1:0]   data3,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready
);

    state_e           state_q;
    state_e           state_d;
    logic [SEL_W-1:0] last_ptr;
    logic             rr_any;
    logic [SEL_W-1:0] rr_sel;
    logic [SEL_W-1:0] pick;
    logic             can_capture;
    logic             capture;
    logic [WIDTH-1:0] mux_data;

    rr_pick u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .any      (rr_any),
        .pick     (rr_sel)
    );

`ifdef MUX_ARB_LOCK_EN
    logic lock_hold;
    logic locked;

    // Lock only binds while the last-granted requester keeps both req and lock high.
    assign locked = lock_hold & req[last_ptr] & lock[last_ptr];
    assign pick   = locked ? last_ptr : rr_sel;
`else
    assign pick = rr_sel;
`endif

    // Data mux, same function as mux_4_1.
    always_comb begin
        case (pick)
            SEL_W'(0): mux_data = data0;
            SEL_W'(1): mux_data = data1;
            SEL_W'(2): mux_data = data2;
            default:   mux_data = data3;
        endcase
    end

    // Next-state and combinational grant; reset suppresses any capture.
    always_comb begin
        state_d     = state_q;
        grant       = '0;
        can_capture = (state_q == ST_IDLE) | out_ready;
        capture     = can_capture & rr_any & ~rst;
        if (capture) begin
            grant[pick] = 1'b1;
        end
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_HOLD;
            ST_HOLD: if (out_ready && !capture) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = (state_q == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_data <= '0;
            sel      <= '0;
            last_ptr <= SEL_W'(NUM_REQ - 1);
`ifdef MUX_ARB_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (capture) begin
                out_data <= mux_data;
                sel      <= pick;
                last_ptr <= pick;
`ifdef MUX_ARB_LOCK_EN
                lock_hold <= lock[pick];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed stimulus queues expected grants and words,
// a negedge monitor pops and compares whenever grant or an accepted output appears.
module tb_mux_rr_arbiter;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } out_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] data0, data1, data2, data3;
    logic [3:0]   lock;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_g[$];
    out_t       exp_o[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [W-1:0] d, input logic [1:0] s);
        out_t o;
        o.data = d;
        o.sel  = s;
        exp_o.push_back(o);
    endtask

    // Monitor: compare grant pulses and accepted words against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (grant != 4'b0) begin
                if (exp_g.size() == 0) chk("grant_unexpected", 32'(grant), 32'h0);
                else                   chk("grant", 32'(grant), 32'(exp_g.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (exp_o.size() == 0) begin
                    chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    out_t e;
                    e = exp_o.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_sel",  32'(sel),      32'(e.sel));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'hF; out_ready = 1'b1; lock = 4'b0;
        data0 = 4'd1; data1 = 4'd2; data2 = 4'd3; data3 = 4'd4;

        // Reset held two cycles with all requests present.
        tick(); tick();
        chk("rst_grant",     32'(grant),     32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_sel",       32'(sel),       32'h0);

        // Full rotation with continuous requests and ready.
        rst = 1'b0; req = 4'hF; out_ready = 1'b1;
        exp_g.push_back(4'h1); exp_g.push_back(4'h2); exp_g.push_back(4'h4);
        exp_g.push_back(4'h8); exp_g.push_back(4'h1);
        push_out(4'd1, 2'd0); push_out(4'd2, 2'd1); push_out(4'd3, 2'd2);
        push_out(4'd4, 2'd3); push_out(4'd1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rot_valid", 32'(out_valid), 32'h1);
        end
        req = 4'h0;
        tick();
        chk("rot_idle_valid", 32'(out_valid), 32'h0);

        // Backpressure: single grant, word frozen while out_ready is low.
        req = 4'b0100; out_ready = 1'b0;
        exp_g.push_back(4'b0100);
        push_out(4'd3, 2'd2);
        tick();
        req = 4'h0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_data",  32'(out_data),  32'h3);
            chk("hold_sel",   32'(sel),       32'h2);
            chk("hold_grant", 32'(grant),     32'h0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_data",  32'(out_data),  32'h3);
        chk("drain_sel",   32'(sel),       32'h2);

        // Pointer wrap: grant 3, then req 1001 goes back to 0.
        req = 4'b1000;
        exp_g.push_back(4'b1000);
        push_out(4'd4, 2'd3);
        tick();
        req = 4'b1001;
        exp_g.push_back(4'b0001);
        push_out(4'd1, 2'd0);
        tick();
        chk("wrap_sel", 32'(sel), 32'h0);
        req = 4'h0;
        tick();

        // Reset in HOLD discards the word; first grant afterwards is requester 0.
        req = 4'hF; out_ready = 1'b0;
        exp_g.push_back(4'b0010);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_sel",   32'(sel),       32'h0);
        chk("mid_rst_data",  32'(out_data),  32'h0);
        rst = 1'b0; out_ready = 1'b1;
        exp_g.push_back(4'b0001);
        push_out(4'd1, 2'd0);
        tick();
        req = 4'h0;
        tick();

`ifdef MUX_ARB_LOCK_EN
        // Lock on requester 1 holds the grant until lock drops.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'hF; lock = 4'b0010; out_ready = 1'b1;
        exp_g.push_back(4'h1); exp_g.push_back(4'h2); exp_g.push_back(4'h2);
        exp_g.push_back(4'h2); exp_g.push_back(4'h4); exp_g.push_back(4'h8);
        exp_g.push_back(4'h1);
        push_out(4'd1, 2'd0); push_out(4'd2, 2'd1); push_out(4'd2, 2'd1);
        push_out(4'd2, 2'd1); push_out(4'd3, 2'd2); push_out(4'd4, 2'd3);
        push_out(4'd1, 2'd0);
        for (int i = 0; i < 4; i++) tick();
        lock = 4'b0;
        for (int i = 0; i < 3; i++) tick();
        req = 4'h0;
        tick();
`endif

        tick(); tick();
        chk("grant_queue_empty", 32'(exp_g.size()), 32'h0);
        chk("out_queue_empty",   32'(exp_o.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
